// File: rtl/packet_dispatch_pkg.sv
// Shared types and constants for the packet dispatcher.
// Imported by the top level and its output register.
package packet_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } dispatch_state_t;

  // Width of the internal port select; covers up to four output ports.
  localparam int DISPATCH_SEL_W = 2;

endpackage

// File: rtl/packet_dispatch_if.sv
// Stream bundle for the dispatcher: one input stream and M_COUNT flattened outputs.
// The slave modport is the dispatcher's view; master is the surrounding system's view.
interface packet_dispatch_if #(
  parameter int M_COUNT    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEST_WIDTH = 2
);

  logic [DATA_WIDTH-1:0]         s_axis_tdata;
  logic [KEEP_WIDTH-1:0]         s_axis_tkeep;
  logic                          s_axis_tvalid;
  logic                          s_axis_tready;
  logic                          s_axis_tlast;
  logic [DEST_WIDTH-1:0]         s_axis_tdest;
  logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata;
  logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep;
  logic [M_COUNT-1:0]            m_axis_tvalid;
  logic [M_COUNT-1:0]            m_axis_tready;
  logic [M_COUNT-1:0]            m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tdest,
    input  m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tdest,
    output m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/packet_dispatch_out_reg.sv
// One-beat output register shared by all ports; the stored select turns the
// single valid bit into a one-hot per-port valid.
module dispatch_out_reg
  import packet_dispatch_pkg::*;
#(
  parameter int M_COUNT    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [KEEP_WIDTH-1:0]         in_keep,
  input  logic                          in_last,
  input  logic [DISPATCH_SEL_W-1:0]     in_sel,
  input  logic [M_COUNT-1:0]            m_ready,
  output logic                          can_load,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_data,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_keep,
  output logic [M_COUNT-1:0]            m_valid,
  output logic [M_COUNT-1:0]            m_last
);

  logic                      out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0]     out_data_reg, out_data_next;
  logic [KEEP_WIDTH-1:0]     out_keep_reg, out_keep_next;
  logic                      out_last_reg, out_last_next;
  logic [DISPATCH_SEL_W-1:0] out_sel_reg, out_sel_next;
  logic [M_COUNT-1:0]        sel_hit;
  logic                      drain;

  generate
    for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_port
      assign sel_hit[gi] = (out_sel_reg == DISPATCH_SEL_W'(gi));
      assign m_valid[gi] = out_valid_reg && sel_hit[gi];
      assign m_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_data_reg;
      assign m_keep[gi*KEEP_WIDTH +: KEEP_WIDTH] = out_keep_reg;
      assign m_last[gi] = out_last_reg;
    end
  endgenerate

  // Only the selected port's ready can drain the register.
  assign drain    = |(m_valid & m_ready);
  assign can_load = !out_valid_reg || drain;

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_keep_next  = out_keep_reg;
    out_last_next  = out_last_reg;
    out_sel_next   = out_sel_reg;
    if (load) begin
      out_valid_next = 1'b1;
      out_data_next  = in_data;
      out_keep_next  = in_keep;
      out_last_next  = in_last;
      out_sel_next   = in_sel;
    end else if (drain) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_sel_reg   <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_last_reg  <= out_last_next;
      out_sel_reg   <= out_sel_next;
    end
  end

endmodule

// File: rtl/packet_dispatch.sv
// Packet-level stream demultiplexer: routes each whole packet to the port named
// by tdest on its first beat, and silently drops (and counts) out-of-range packets.
module packet_dispatch
  import packet_dispatch_pkg::*;
#(
  parameter int M_COUNT    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEST_WIDTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  packet_dispatch_if.slave     axis,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam logic [DEST_WIDTH:0] M_COUNT_L = (DEST_WIDTH + 1)'(M_COUNT);

  dispatch_state_t        state_reg, state_next;
  logic [DEST_WIDTH-1:0]  sel_reg, sel_next;
  logic [CNT_WIDTH-1:0]   drop_count_reg, drop_count_next;
  logic                   s_ready;
  logic                   can_load;
  logic                   load;
  logic                   dest_ok;

  assign dest_ok = ({1'b0, axis.s_axis_tdest} < M_COUNT_L);

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    drop_count_next = drop_count_reg;
    s_ready         = 1'b0;
    load            = 1'b0;
    case (state_reg)
      IDLE: begin
        // Decision cycle: the input is never accepted here, only tdest is sampled.
        if (axis.s_axis_tvalid) begin
          sel_next = axis.s_axis_tdest;
          if (dest_ok) begin
            state_next = FWD;
          end else begin
            state_next = DROP;
            if (drop_count_reg != '1) begin
              drop_count_next = drop_count_reg + 1'b1;
            end
          end
        end
      end
      FWD: begin
        s_ready = can_load;
        load    = axis.s_axis_tvalid && can_load;
        if (load && axis.s_axis_tlast) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (axis.s_axis_tvalid && axis.s_axis_tlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign axis.s_axis_tready = s_ready;
  assign busy               = (state_reg != IDLE);
  assign drop_count         = drop_count_reg;

  dispatch_out_reg #(
    .M_COUNT    (M_COUNT),
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in_data  (axis.s_axis_tdata),
    .in_keep  (axis.s_axis_tkeep),
    .in_last  (axis.s_axis_tlast),
    .in_sel   (DISPATCH_SEL_W'(sel_reg)),
    .m_ready  (axis.m_axis_tready),
    .can_load (can_load),
    .m_data   (axis.m_axis_tdata),
    .m_keep   (axis.m_axis_tkeep),
    .m_valid  (axis.m_axis_tvalid),
    .m_last   (axis.m_axis_tlast)
  );

endmodule

// File: tb/tb_packet_dispatch.sv
// Directed self-checking bench for packet_dispatch (M_COUNT=3, 2-bit drop counter).
module tb_packet_dispatch;

  localparam int M  = 3;
  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct {
    int          port;
    logic [63:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [1:0]  drop_count;
  logic [M-1:0] mready_base;
  logic [M-1:0] tog_mask;
  logic        tog_phase = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          bp_viol = 0;
  int          drop_viol = 0;
  bit          bp_mon = 1'b0;
  bit          drop_mon = 1'b0;
  beat_t       rx[$];

  packet_dispatch_if #(.M_COUNT(M), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(2)) ifc ();

  packet_dispatch #(
    .M_COUNT(M), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(2), .CNT_WIDTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .axis       (ifc),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  assign ifc.m_axis_tready = mready_base ^ (tog_mask & {M{tog_phase}});

  always @(posedge clk) tog_phase <= ~tog_phase;

  // Capture every output handshake with the edge number it happened on.
  always @(posedge clk) begin
    beat_t b;
    for (int i = 0; i < M; i++) begin
      if (ifc.m_axis_tvalid[i] && ifc.m_axis_tready[i]) begin
        b.port = i;
        b.data = ifc.m_axis_tdata[i*DW +: DW];
        b.last = ifc.m_axis_tlast[i];
        b.cyc  = cyc;
        rx.push_back(b);
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bp_mon && (|(ifc.m_axis_tvalid & ~ifc.m_axis_tready)) && ifc.s_axis_tready)
      bp_viol++;
    if (drop_mon && ((|ifc.m_axis_tvalid) || (busy && !ifc.s_axis_tready)))
      drop_viol++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet; tdest is corrupted on non-first beats to show it is ignored.
  task automatic send_pkt(input logic [1:0] dest, input int len, input logic [63:0] base,
                          output int start_cyc, output int ncyc);
    bit got;
    bit timeout;
    ncyc = 0;
    timeout = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < len && !timeout; k++) begin
      ifc.s_axis_tdata  = base + 64'(k);
      ifc.s_axis_tkeep  = '1;
      ifc.s_axis_tlast  = (k == len - 1);
      ifc.s_axis_tdest  = (k == 0) ? dest : ~dest;
      ifc.s_axis_tvalid = 1'b1;
      got = 1'b0;
      while (!got && !timeout) begin
        @(negedge clk);
        got = ifc.s_axis_tready;
        step();
        ncyc++;
        if (ncyc > 300) begin
          timeout = 1'b1;
          chk("send_timeout", 64'(ncyc), 64'(300));
        end
      end
    end
    ifc.s_axis_tvalid = 1'b0;
    ifc.s_axis_tlast  = 1'b0;
  endtask

  task automatic expect_pkt(input int port, input logic [63:0] base, input int len,
                            input int first_cyc, input bit timed, output int last_cyc);
    beat_t b;
    int c0;
    c0 = first_cyc;
    last_cyc = -1;
    for (int k = 0; k < len; k++) begin
      if (rx.size() == 0) begin
        chk("rx_missing_beat", 64'(k), 64'(len));
        break;
      end
      b = rx.pop_front();
      if (c0 < 0) c0 = b.cyc;
      chk($sformatf("rx_port_b%0d", k), 64'(b.port), 64'(port));
      chk($sformatf("rx_data_b%0d", k), b.data, base + 64'(k));
      chk($sformatf("rx_last_b%0d", k), 64'(b.last), 64'(k == len - 1));
      if (timed && !(k == 0 && first_cyc < 0))
        chk($sformatf("rx_cycle_b%0d", k), 64'(b.cyc), 64'(c0 + k));
      last_cyc = b.cyc;
    end
  endtask

  initial begin
    int st, n, l1, l2, l3, dummy;
    logic [1:0] exp_cnt;

    rst = 1'b1;
    ifc.s_axis_tdata  = '0;
    ifc.s_axis_tkeep  = '0;
    ifc.s_axis_tvalid = 1'b0;
    ifc.s_axis_tlast  = 1'b0;
    ifc.s_axis_tdest  = '0;
    mready_base = '1;
    tog_mask    = '0;
    repeat (3) step();

    // Reset values
    chk("rst_s_tready", 64'(ifc.s_axis_tready), 64'd0);
    chk("rst_m_tvalid", 64'(ifc.m_axis_tvalid), 64'd0);
    chk("rst_m_tdata",  64'(|ifc.m_axis_tdata), 64'd0);
    chk("rst_m_tkeep",  64'(ifc.m_axis_tkeep),  64'd0);
    chk("rst_m_tlast",  64'(ifc.m_axis_tlast),  64'd0);
    chk("rst_busy",     64'(busy),              64'd0);
    chk("rst_drop_cnt", 64'(drop_count),        64'd0);
    rst = 1'b0;
    step();

    // Basic forward: 4 beats to port 1, decision edge + 2 to first output
    send_pkt(2'd1, 4, 64'h1000, st, n);
    chk("basic_in_cycles", 64'(n), 64'd5);
    step(); step();
    chk("basic_busy_after", 64'(busy), 64'd0);
    expect_pkt(1, 64'h1000, 4, st + 2, 1'b1, dummy);
    chk("basic_rx_extra", 64'(rx.size()), 64'd0);

    // Back-to-back packets 0, 2, 0 with one bubble between them
    send_pkt(2'd0, 3, 64'h2000, st, n);
    send_pkt(2'd2, 3, 64'h3000, st, n);
    send_pkt(2'd0, 3, 64'h4000, st, n);
    step(); step();
    expect_pkt(0, 64'h2000, 3, -1, 1'b1, l1);
    expect_pkt(2, 64'h3000, 3, l1 + 2, 1'b1, l2);
    expect_pkt(0, 64'h4000, 3, l2 + 2, 1'b1, l3);
    chk("b2b_rx_extra", 64'(rx.size()), 64'd0);

    // Back-pressure: port 2 ready toggles every cycle
    tog_mask = 3'b100;
    bp_mon = 1'b1;
    send_pkt(2'd2, 8, 64'h5000, st, n);
    repeat (4) step();
    bp_mon = 1'b0;
    tog_mask = '0;
    chk("bp_stalled", 64'(n > 9), 64'd1);
    chk("bp_viol", 64'(bp_viol), 64'd0);
    expect_pkt(2, 64'h5000, 8, -1, 1'b0, dummy);
    chk("bp_rx_extra", 64'(rx.size()), 64'd0);

    // Drop: tdest=3 is out of range, then a normal packet to port 0
    step();
    drop_mon = 1'b1;
    send_pkt(2'd3, 5, 64'h6000, st, n);
    drop_mon = 1'b0;
    chk("drop_in_cycles", 64'(n), 64'd6);
    chk("drop_cnt_1", 64'(drop_count), 64'd1);
    chk("drop_viol", 64'(drop_viol), 64'd0);
    send_pkt(2'd0, 2, 64'h7000, st, n);
    step(); step();
    expect_pkt(0, 64'h7000, 2, st + 2, 1'b1, dummy);
    chk("drop_rx_extra", 64'(rx.size()), 64'd0);

    // Single-beat packets alternating 0/1 while the idle port 2 ready toggles
    tog_mask = 3'b100;
    send_pkt(2'd0, 1, 64'h8000, st, n);
    chk("single0_cycles", 64'(n), 64'd2);
    send_pkt(2'd1, 1, 64'h8100, st, n);
    chk("single1_cycles", 64'(n), 64'd2);
    send_pkt(2'd0, 1, 64'h8200, st, n);
    send_pkt(2'd1, 1, 64'h8300, st, n);
    step(); step();
    tog_mask = '0;
    expect_pkt(0, 64'h8000, 1, -1, 1'b1, l1);
    expect_pkt(1, 64'h8100, 1, l1 + 2, 1'b1, l2);
    expect_pkt(0, 64'h8200, 1, l2 + 2, 1'b1, l3);
    expect_pkt(1, 64'h8300, 1, l3 + 2, 1'b1, dummy);
    chk("single_rx_extra", 64'(rx.size()), 64'd0);

    // Reset in the middle of a packet to port 1
    ifc.s_axis_tdata  = 64'h9000;
    ifc.s_axis_tkeep  = '1;
    ifc.s_axis_tlast  = 1'b0;
    ifc.s_axis_tdest  = 2'd1;
    ifc.s_axis_tvalid = 1'b1;
    step(); step(); step();
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_m_tvalid", 64'(ifc.m_axis_tvalid), 64'b010);
    rst = 1'b1;
    step();
    chk("mrst_s_tready", 64'(ifc.s_axis_tready), 64'd0);
    chk("mrst_m_tvalid", 64'(ifc.m_axis_tvalid), 64'd0);
    chk("mrst_m_tdata",  64'(|ifc.m_axis_tdata), 64'd0);
    chk("mrst_m_tkeep",  64'(ifc.m_axis_tkeep),  64'd0);
    chk("mrst_m_tlast",  64'(ifc.m_axis_tlast),  64'd0);
    chk("mrst_busy",     64'(busy),              64'd0);
    chk("mrst_drop_cnt", 64'(drop_count),        64'd0);
    rst = 1'b0;
    ifc.s_axis_tvalid = 1'b0;
    step();
    rx.delete();

    // Counter saturation with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      send_pkt(2'd3, 2, 64'hA000 + 64'(i * 16), st, n);
      exp_cnt = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
      chk($sformatf("sat_drop_cnt_%0d", i), 64'(drop_count), 64'(exp_cnt));
    end
    step(); step();
    chk("sat_rx_none", 64'(rx.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
